// File: rtl/camera_pkg.sv
// Shared definitions for the camera datapath blocks: loader FSM state
// encoding and the widths of its byte-index and write-strobe counters.
package camera_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_BYTE = 3'd1,
    ST_FETCH     = 3'd2,
    ST_SETUP     = 3'd3,
    ST_STROBE    = 3'd4,
    ST_HOLD      = 3'd5,
    ST_DONE      = 3'd6
  } ld_state_e;

  localparam int BYTE_IDX_W = 2;
  localparam int WE_CNT_W   = 4;

  typedef logic [BYTE_IDX_W-1:0] byte_idx_t;
  typedef logic [WE_CNT_W-1:0]   we_cnt_t;

endpackage

// File: rtl/sram_loader_if.sv
// Bus bundle between the SRAM loader, the main sequencer, the RS232C
// receiver and the SRAM write port.
interface sram_loader_if;
  import camera_pkg::*;

  // load_kick is a one-cycle start pulse; load_done a one-cycle end pulse.
  // rs_rx_status high means a byte is held in rs_rx_data; a one-cycle
  // rs_rx_fetch pops it, and status may take one more cycle to drop.
  logic        load_kick;
  logic        load_done;
  logic        load_error;
  logic [17:0] last_addr;
  logic        rs_rx_status;
  logic [7:0]  rs_rx_data;
  logic        rs_rx_fetch;
  logic        s1_WE;
  logic [17:0] s1_Addr;
  logic [31:0] s1_WD;

  modport master (
    input  load_kick, last_addr, rs_rx_status, rs_rx_data,
    output load_done, load_error, rs_rx_fetch, s1_WE, s1_Addr, s1_WD
  );

  modport slave (
    output load_kick, last_addr, rs_rx_status, rs_rx_data,
    input  load_done, load_error, rs_rx_fetch, s1_WE, s1_Addr, s1_WD
  );

endinterface

// File: rtl/sram_loader.sv
// Receives bytes from the RS232C receiver, packs four per word (first byte
// least significant) and writes them to SRAM words 0..last_addr.
module sram_loader
  import camera_pkg::*;
#(
  parameter int unsigned WE_LOW_CYCLES  = 2,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd5_000_000
) (
  input  logic             clk,
  input  logic             reset_n,
  sram_loader_if.master    bus,
  output ld_state_e        dbg_state_o
);

  localparam we_cnt_t     WE_LAST  = we_cnt_t'(WE_LOW_CYCLES - 1);
  localparam logic [23:0] TMO_LAST = TIMEOUT_CYCLES - 24'd1;

  ld_state_e   state_q;
  logic [17:0] last_q;
  logic [17:0] addr_q;
  logic [31:0] wd_q;
  byte_idx_t   byte_q;
  we_cnt_t     we_cnt_q;
  logic [23:0] tmo_q;
  logic        skip_q;
  logic        we_q;
  logic        fetch_q;
  logic        done_q;
  logic        err_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      last_q   <= '0;
      addr_q   <= '0;
      wd_q     <= '0;
      byte_q   <= '0;
      we_cnt_q <= '0;
      tmo_q    <= '0;
      skip_q   <= 1'b0;
      we_q     <= 1'b1;
      fetch_q  <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      fetch_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.load_kick) begin
            last_q  <= bus.last_addr;
            addr_q  <= '0;
            byte_q  <= '0;
            tmo_q   <= '0;
            err_q   <= 1'b0;
            skip_q  <= 1'b0;
            state_q <= ST_WAIT_BYTE;
          end
        end
        ST_WAIT_BYTE: begin
          // skip_q masks the stale status seen right after a fetch
          skip_q <= 1'b0;
          if (bus.rs_rx_status && !skip_q) begin
            fetch_q <= 1'b1;
            state_q <= ST_FETCH;
          end else if (tmo_q == TMO_LAST) begin
            err_q   <= 1'b1;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            tmo_q <= tmo_q + 24'd1;
          end
        end
        ST_FETCH: begin
          wd_q[{byte_q, 3'b000} +: 8] <= bus.rs_rx_data;
          tmo_q <= '0;
          if (byte_q == byte_idx_t'(3)) begin
            byte_q  <= '0;
            state_q <= ST_SETUP;
          end else begin
            byte_q  <= byte_q + 1'b1;
            skip_q  <= 1'b1;
            state_q <= ST_WAIT_BYTE;
          end
        end
        ST_SETUP: begin
          we_q     <= 1'b0;
          we_cnt_q <= '0;
          state_q  <= ST_STROBE;
        end
        ST_STROBE: begin
          if (we_cnt_q == WE_LAST) begin
            we_q    <= 1'b1;
            state_q <= ST_HOLD;
          end else begin
            we_cnt_q <= we_cnt_q + 1'b1;
          end
        end
        ST_HOLD: begin
          // compare before increment so last_addr = 3FFFF never wraps early
          if (addr_q == last_q) begin
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            addr_q  <= addr_q + 18'd1;
            state_q <= ST_WAIT_BYTE;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.s1_WE       = we_q;
  assign bus.s1_Addr     = addr_q;
  assign bus.s1_WD       = wd_q;
  assign bus.rs_rx_fetch = fetch_q;
  assign bus.load_done   = done_q;
  assign bus.load_error  = err_q;
  assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_sram_loader.sv
// Bench for sram_loader: receiver model, SRAM write monitor with expected
// word queue, table-driven loads and hand-written corner sequences.
module tb_sram_loader;
  import camera_pkg::*;

  localparam int WE_LOW = 2;

  logic      clk = 1'b0;
  logic      reset_n = 1'b0;
  ld_state_e dbg_state;

  sram_loader_if ifc();

  sram_loader #(.WE_LOW_CYCLES(WE_LOW), .TIMEOUT_CYCLES(24'd100)) dut (
    .clk(clk), .reset_n(reset_n), .bus(ifc.master), .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  logic [49:0] exp_q[$];
  logic [7:0]  rx_q[$];

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- receiver model (status drops one cycle late) ----------------
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ifc.rs_rx_status <= 1'b0;
      ifc.rs_rx_data   <= 8'h00;
    end else begin
      ifc.rs_rx_status <= (rx_q.size() > 0);
      ifc.rs_rx_data   <= (rx_q.size() > 0) ? rx_q[0] : 8'h00;
      if (ifc.rs_rx_fetch && rx_q.size() > 0) void'(rx_q.pop_front());
    end
  end

  // ---------------- monitor / scoreboard ----------------
  bit          mon_en = 1'b1;
  logic        prev_we = 1'b1;
  logic        prev_done = 1'b0;
  logic [17:0] prev_addr = '0;
  logic [31:0] prev_wd = '0;
  int low_len = 0;
  int fetch_cnt = 0, write_cnt = 0, done_cnt = 0;
  int last_fetch_cyc = -1, done_cyc = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (prev_we && !ifc.s1_WE) begin
        check("setup_stable", {prev_addr, prev_wd}, {ifc.s1_Addr, ifc.s1_WD});
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected none",
                   ifc.s1_Addr, ifc.s1_WD);
        end else begin
          check("write_word", {ifc.s1_Addr, ifc.s1_WD}, exp_q.pop_front());
        end
        write_cnt++;
        low_len = 1;
      end else if (!prev_we && !ifc.s1_WE) begin
        low_len++;
        check("strobe_stable", {prev_addr, prev_wd}, {ifc.s1_Addr, ifc.s1_WD});
      end else if (!prev_we && ifc.s1_WE) begin
        check("we_low_len", low_len, WE_LOW);
        check("hold_stable", {prev_addr, prev_wd}, {ifc.s1_Addr, ifc.s1_WD});
      end
      if (ifc.rs_rx_fetch) begin
        fetch_cnt++;
        if (last_fetch_cyc >= 0) check("fetch_gap_ok", (cyc - last_fetch_cyc) >= 2, 1);
        last_fetch_cyc = cyc;
      end
      if (ifc.load_done) begin
        done_cnt++;
        done_cyc = cyc;
        check("done_pulse_1cyc", prev_done, 0);
      end
    end
    prev_we   = ifc.s1_WE;
    prev_addr = ifc.s1_Addr;
    prev_wd   = ifc.s1_WD;
    prev_done = ifc.load_done;
  end

  // ---------------- driver tasks ----------------
  task automatic tick(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic kick(logic [17:0] last);
    ifc.last_addr = last;
    ifc.load_kick = 1'b1;
    tick();
    ifc.load_kick = 1'b0;
  endtask

  task automatic clear_counts();
    fetch_cnt = 0;
    write_cnt = 0;
    done_cnt = 0;
    last_fetch_cyc = -1;
  endtask

  // step == 0 selects random bytes; trickle inserts random idle gaps
  task automatic gen_load(int nwords, logic [7:0] base, logic [7:0] step, bit trickle);
    logic [7:0]  b[$];
    logic [7:0]  v;
    logic [17:0] a;
    for (int i = 0; i < nwords * 4; i++) begin
      v = (step == 8'h00) ? 8'($urandom_range(0, 255)) : 8'(base + step * i);
      b.push_back(v);
    end
    for (int w = 0; w < nwords; w++) begin
      a = w[17:0];
      exp_q.push_back({a, b[4*w+3], b[4*w+2], b[4*w+1], b[4*w]});
    end
    for (int i = 0; i < b.size(); i++) begin
      rx_q.push_back(b[i]);
      if (trickle) tick($urandom_range(0, 6));
    end
  endtask

  task automatic wait_done(string name, int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      tick();
      n++;
    end
    check({name, "_done_seen"}, done_cnt > 0, 1);
    tick(3);
  endtask

  task automatic check_load(string name, int exp_w, int exp_f, bit exp_err);
    check({name, "_writes"},  write_cnt, exp_w);
    check({name, "_fetches"}, fetch_cnt, exp_f);
    check({name, "_done_cnt"}, done_cnt, 1);
    check({name, "_error"},   ifc.load_error, exp_err);
    check({name, "_exp_left"}, exp_q.size(), 0);
    check({name, "_rx_left"}, rx_q.size(), 0);
    check({name, "_state"},   dbg_state, ST_IDLE);
  endtask

  // ---------------- test vectors ----------------
  typedef struct {
    logic [17:0] last;
    logic [7:0]  base;
    logic [7:0]  step;
    bit          trickle;
    int          exp_writes;
    int          exp_fetches;
    bit          exp_err;
  } vec_t;

  vec_t vecs[4];
  int   n;

  initial begin
    vecs[0] = '{18'd1, 8'h11, 8'h11, 1'b0, 2, 8,  1'b0};
    vecs[1] = '{18'd0, 8'hA0, 8'h01, 1'b1, 1, 4,  1'b0};
    vecs[2] = '{18'd2, 8'h5A, 8'h13, 1'b1, 3, 12, 1'b0};
    vecs[3] = '{18'd3, 8'h00, 8'h00, 1'b1, 4, 16, 1'b0};

    ifc.load_kick = 1'b0;
    ifc.last_addr = '0;
    tick(3);
    check("rst_we",    ifc.s1_WE, 1);
    check("rst_addr",  ifc.s1_Addr, 0);
    check("rst_wd",    ifc.s1_WD, 0);
    check("rst_fetch", ifc.rs_rx_fetch, 0);
    check("rst_done",  ifc.load_done, 0);
    check("rst_error", ifc.load_error, 0);
    check("rst_state", dbg_state, ST_IDLE);
    reset_n = 1'b1;
    tick(2);

    for (int i = 0; i < 4; i++) begin
      clear_counts();
      kick(vecs[i].last);
      gen_load(int'(vecs[i].last) + 1, vecs[i].base, vecs[i].step, vecs[i].trickle);
      wait_done($sformatf("v%0d", i), 2000);
      check_load($sformatf("v%0d", i), vecs[i].exp_writes, vecs[i].exp_fetches, vecs[i].exp_err);
    end

    // timeout: partial word, then silence
    clear_counts();
    kick(18'd0);
    rx_q.push_back(8'hC1);
    rx_q.push_back(8'hC2);
    rx_q.push_back(8'hC3);
    wait_done("tmo", 400);
    check("tmo_latency", done_cyc - last_fetch_cyc, 101);
    check_load("tmo", 0, 3, 1'b1);
    tick(5);
    check("tmo_error_holds", ifc.load_error, 1);

    // kick mid-load is ignored; original last_addr stands
    clear_counts();
    kick(18'd1);
    tick(2);
    check("kick_clears_error", ifc.load_error, 0);
    gen_load(2, 8'h30, 8'h07, 1'b0);
    tick(10);
    check("mid_busy", dbg_state != ST_IDLE, 1);
    kick(18'd5);
    wait_done("midkick", 2000);
    check_load("midkick", 2, 8, 1'b0);

    // status held high for 12 bytes back to back
    clear_counts();
    for (int i = 0; i < 12; i++) rx_q.push_back(8'(8'hE0 + i));
    for (int w = 0; w < 3; w++)
      exp_q.push_back({18'(w), 8'(8'hE3 + 4*w), 8'(8'hE2 + 4*w), 8'(8'hE1 + 4*w), 8'(8'hE0 + 4*w)});
    kick(18'd2);
    wait_done("b2b", 2000);
    check_load("b2b", 3, 12, 1'b0);

    // reset asserted mid-strobe forces WE high without a clock edge
    mon_en = 1'b0;
    clear_counts();
    kick(18'd3);
    gen_load(4, 8'h40, 8'h01, 1'b0);
    n = 0;
    while (ifc.s1_WE && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("rst_strobe_reached", ifc.s1_WE, 0);
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_async_we",    ifc.s1_WE, 1);
    check("rst_async_state", dbg_state, ST_IDLE);
    check("rst_async_addr",  ifc.s1_Addr, 0);
    rx_q.delete();
    exp_q.delete();
    tick(2);
    reset_n = 1'b1;
    tick(2);
    mon_en = 1'b1;
    clear_counts();
    kick(18'd1);
    gen_load(2, 8'h90, 8'h05, 1'b1);
    wait_done("restart", 2000);
    check_load("restart", 2, 8, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sram_loader.md
SRAM_LOADER -- requirements
Module: sram_loader

Interface
REQ-001 Parameter WE_LOW_CYCLES, default 2: cycles s1_WE is held low per word write (legal 1..15).
REQ-002 Parameter TIMEOUT_CYCLES, default 24'd5_000_000: idle cycles allowed between received bytes before abort.
REQ-003 clk  input  1  single clock for all logic.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 load_kick  input  1  one-cycle start pulse from main sequencer.
REQ-006 load_done  output  1  one-cycle pulse on completion or abort.
REQ-007 load_error  output  1  high when the last load was aborted by timeout.
REQ-008 last_addr  input  18  last SRAM word address to write (inclusive).
REQ-009 rs_rx_status  input  1  high when the RS232C receiver holds an unread byte.
REQ-010 rs_rx_data  input  8  received byte, valid while rs_rx_status high.
REQ-011 rs_rx_fetch  output  1  one-cycle pulse that pops the held byte.
REQ-012 s1_WE  output  1  SRAM write enable, active-low.
REQ-013 s1_Addr  output  18  SRAM word address.
REQ-014 s1_WD  output  32  SRAM write data.

Function
REQ-015 Block SHALL receive bytes over RS232C and write them to SRAM words 0..last_addr, the write-side counterpart of the SRAM-to-RS232C dump path.
REQ-016 States SHALL be IDLE, WAIT_BYTE, FETCH, SETUP, STROBE, HOLD, DONE.
REQ-017 IDLE: load_kick=1 -> capture last_addr, clear address counter, byte index, timeout counter and load_error; go WAIT_BYTE; load_kick in any other state SHALL be ignored.
REQ-018 WAIT_BYTE: rs_rx_status=1 -> FETCH; rs_rx_fetch SHALL NOT be asserted in the same cycle status is first seen.
REQ-019 FETCH: assert rs_rx_fetch for exactly one cycle and latch rs_rx_data into s1_WD[8k+7:8k], k = byte index 0..3 (first byte is least significant).
REQ-020 After FETCH, k<3 -> increment k, go WAIT_BYTE; k=3 -> k=0, go SETUP.
REQ-021 rs_rx_status SHALL be ignored in the cycle following FETCH (receiver status deassert latency).
REQ-022 SETUP: s1_Addr and s1_WD stable, s1_WE=1, one cycle.
REQ-023 STROBE: s1_WE=0 for exactly WE_LOW_CYCLES cycles; s1_Addr and s1_WD SHALL NOT change.
REQ-024 HOLD: s1_WE=1, address and data unchanged, one cycle; if s1_Addr==captured last_addr -> DONE, else increment s1_Addr, go WAIT_BYTE.
REQ-025 Completion compare SHALL precede increment, so last_addr=18'h3FFFF writes all 262144 words without premature wrap.
REQ-026 Bytes arriving during SETUP/STROBE/HOLD SHALL stay pending in the receiver and be fetched afterwards; none dropped.
REQ-027 Timeout counter SHALL clear on every FETCH and count in WAIT_BYTE only; reaching TIMEOUT_CYCLES -> load_error=1, go DONE; a partial word SHALL NOT be written.
REQ-028 DONE: load_done=1 for one cycle, then IDLE; load_error holds until the next accepted load_kick.
REQ-029 s1_WE SHALL be 1 in every state except STROBE.

Reset
REQ-030 reset_n=0 SHALL asynchronously force IDLE, s1_WE=1, s1_Addr=0, s1_WD=0, rs_rx_fetch=0, load_done=0, load_error=0, counters=0.
REQ-031 Reset during STROBE SHALL raise s1_WE immediately; the interrupted write is not resumed.
REQ-032 Deassertion SHALL be synchronised to clk by the existing clock/reset block.

Structure
REQ-033 State encoding and the byte-index/WE-count widths SHALL live in a shared package camera_pkg; parameters stay local.
REQ-034 No sub-module; single FSM with address, byte, strobe and timeout counters, size about 150-250 RTL lines.

Verification
REQ-035 last_addr=1, bytes 11 22 33 44 55 66 77 88 -> writes addr0=32'h44332211, addr1=32'h88776655, one load_done pulse, load_error=0.
REQ-036 Each write: s1_WE low exactly 2 cycles, addr/data stable 1 cycle before and after; rs_rx_fetch pulses exactly 8 times.
REQ-037 last_addr=0, 3 bytes then silence, TIMEOUT_CYCLES=100 -> no write, load_done after 100 idle cycles, load_error=1.
REQ-038 load_kick asserted mid-load -> ignored; transfer completes with original last_addr.
REQ-039 reset_n=0 during STROBE -> s1_WE=1 without waiting for a clk edge, state IDLE, new kick restarts at addr 0.
REQ-040 rs_rx_status held high continuously for 12 bytes -> back-to-back fetches spaced at least 2 cycles apart, no byte lost or duplicated.
